uart_led_cmd_ctrl: RTL and testbench

- Framed-command controller between the UART receiver's byte/done interface and the board LEDs.
- Parses 4-byte frames: SYNC, CMD, ARG, CHK. Validates the checksum and applies SET/TOGGLE/BLINK commands to a 4-bit LED register.
- Runs an inter-byte timeout and keeps error status and an error counter.
- Replaces direct rx_data-to-LED latching in the LED top level.

---
 rtl/uart_led_cmd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_led_cmd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_led_cmd_ctrl.sv
// uart_led_cmd_ctrl
//   Framed-command controller sitting between the UART receiver byte/done
//   interface and the board LEDs. A frame is four bytes: SYNC, CMD, ARG, CHK.
//   CHK must equal (SYNC + CMD + ARG) mod 256. Valid frames apply SET (01),
//   TOGGLE (02) or BLINK (03) to a 4-bit LED register. Aborted frames
//   (timeout, bad checksum, unknown command) raise frame_err and bump a
//   saturating error counter.
//
// Handshake: rx_data is sampled only on a rising clk edge where rx_done=1.
//   There is no back-pressure; every strobe is consumed the cycle it arrives.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   rx_data    received byte, valid when rx_done=1
//   rx_done    one-cycle strobe per received byte
//   led        led_reg XOR (blink_mask AND blink_phase)
//   busy       frame in progress (state != IDLE)
//   frame_ok   one-cycle pulse, valid frame executed
//   frame_err  one-cycle pulse, frame aborted
//   err_code   last error: 00 none, 01 timeout, 10 checksum, 11 bad cmd
//   err_count  aborted-frame count, saturating at 255
module uart_led_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE         = 8'hA5,
  parameter int         TIMEOUT_CYCLES    = 500000,
  parameter int         BLINK_HALF_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [3:0] led,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BLINK_HALF_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GET_CMD = 2'd1;
  localparam logic [1:0] GET_ARG = 2'd2;
  localparam logic [1:0] GET_CHK = 2'd3;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHKSUM  = 2'b10;
  localparam logic [1:0] ERR_BADCMD  = 2'b11;

  logic [1:0]    state, state_n;
  logic [7:0]    cmd_reg, cmd_n;
  logic [7:0]    arg_reg, arg_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [BW-1:0] bl_cnt, bl_n;
  logic [3:0]    led_reg, led_reg_n;
  logic [3:0]    mask, mask_n;
  logic          phase, phase_n;
  logic [1:0]    err_code_n;
  logic [7:0]    err_count_n;
  logic          ok_n, err_n;
  logic          abort;
  logic [1:0]    abort_code;
  logic [7:0]    chk_expected;

  assign chk_expected = 8'(SYNC_BYTE + cmd_reg + arg_reg);

  always_comb begin
    state_n     = state;
    cmd_n       = cmd_reg;
    arg_n       = arg_reg;
    to_n        = to_cnt;
    led_reg_n   = led_reg;
    mask_n      = mask;
    ok_n        = 1'b0;
    abort       = 1'b0;
    abort_code  = 2'b00;
    err_code_n  = err_code;
    err_count_n = err_count;

    // Blink engine free-runs while any mask bit is set; a command executed
    // below may override these values on the same edge.
    if (mask != 4'h0) begin
      if (bl_cnt == BL_LAST) begin
        bl_n    = '0;
        phase_n = ~phase;
      end else begin
        bl_n    = bl_cnt + BW'(1);
        phase_n = phase;
      end
    end else begin
      bl_n    = '0;
      phase_n = 1'b0;
    end

    if (state == IDLE) begin
      to_n = '0;
      if (rx_done && rx_data == SYNC_BYTE) state_n = GET_CMD;
    end else if (rx_done) begin
      // An arriving byte always wins over timeout expiry.
      to_n = '0;
      case (state)
        GET_CMD: begin
          cmd_n   = rx_data;
          state_n = GET_ARG;
        end
        GET_ARG: begin
          arg_n   = rx_data;
          state_n = GET_CHK;
        end
        default: begin
          state_n = IDLE;
          if (rx_data != chk_expected) begin
            abort      = 1'b1;
            abort_code = ERR_CHKSUM;
          end else begin
            case (cmd_reg)
              8'h01: begin
                led_reg_n = arg_reg[3:0];
                mask_n    = 4'h0;
                phase_n   = 1'b0;
                bl_n      = '0;
                ok_n      = 1'b1;
              end
              8'h02: begin
                led_reg_n = led_reg ^ arg_reg[3:0];
                ok_n      = 1'b1;
              end
              8'h03: begin
                mask_n  = arg_reg[3:0];
                phase_n = 1'b0;
                bl_n    = '0;
                ok_n    = 1'b1;
              end
              default: begin
                abort      = 1'b1;
                abort_code = ERR_BADCMD;
              end
            endcase
          end
        end
      endcase
    end else if (to_cnt == TO_LAST) begin
      state_n    = IDLE;
      to_n       = '0;
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end else begin
      to_n = to_cnt + TW'(1);
    end

    err_n = abort;
    if (abort) begin
      err_code_n = abort_code;
      if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_reg   <= 8'h00;
      arg_reg   <= 8'h00;
      to_cnt    <= '0;
      bl_cnt    <= '0;
      led_reg   <= 4'h0;
      mask      <= 4'h0;
      phase     <= 1'b0;
      led       <= 4'h0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      err_count <= 8'h00;
    end else begin
      state     <= state_n;
      cmd_reg   <= cmd_n;
      arg_reg   <= arg_n;
      to_cnt    <= to_n;
      bl_cnt    <= bl_n;
      led_reg   <= led_reg_n;
      mask      <= mask_n;
      phase     <= phase_n;
      // led and busy are registered from next-state values so they line up
      // with the internal registers they are derived from.
      led       <= led_reg_n ^ (mask_n & {4{phase_n}});
      busy      <= (state_n != IDLE);
      frame_ok  <= ok_n;
      frame_err <= err_n;
      err_code  <= err_code_n;
      err_count <= err_count_n;
    end
  end

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// tb_uart_led_cmd_ctrl
//   Directed bench for uart_led_cmd_ctrl with TIMEOUT_CYCLES=16 and
//   BLINK_HALF_CYCLES=4. Inputs change on the falling edge; outputs are
//   sampled on the falling edge after the accepting rising edge.
module tb_uart_led_cmd_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [3:0] led;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  uart_led_cmd_ctrl #(
    .SYNC_BYTE        (8'hA5),
    .TIMEOUT_CYCLES   (16),
    .BLINK_HALF_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .led      (led),
    .busy     (busy),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .err_count(err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: return on the falling edge right after the byte is taken
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({led, busy, frame_ok, frame_err, err_code, err_count} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got led=%0h busy=%0b ok=%0b err=%0b code=%0d cnt=%0d required all 0",
               led, busy, frame_ok, frame_err, err_code, err_count);
    end
  endtask

  task automatic test_set;
    send_byte(8'hA5);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL set_busy: got %0b required 1", busy); end
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'hAB);
    checks++;
    if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin
      failures++; $display("FAIL set_pulse: got ok=%0b err=%0b required ok=1 err=0", frame_ok, frame_err);
    end
    checks++;
    if (led !== 4'h5) begin failures++; $display("FAIL set_led: got %0h required 5", led); end
    @(negedge clk);
    checks++;
    if (frame_ok !== 1'b0 || busy !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL set_after: got ok=%0b busy=%0b cnt=%0d required 0 0 0", frame_ok, busy, err_count);
    end
  endtask

  task automatic test_toggle_and_chksum;
    send_frame(8'hA5, 8'h02, 8'h0F, 8'hB6);
    checks++;
    if (led !== 4'hA || frame_ok !== 1'b1) begin
      failures++; $display("FAIL toggle: got led=%0h ok=%0b required led=a ok=1", led, frame_ok);
    end
    send_frame(8'hA5, 8'h01, 8'h05, 8'h00);
    checks++;
    if (frame_err !== 1'b1 || frame_ok !== 1'b0 || err_code !== 2'b10 || err_count !== 8'd1 || led !== 4'hA) begin
      failures++;
      $display("FAIL chksum_err: got err=%0b ok=%0b code=%0d cnt=%0d led=%0h required 1 0 2 1 a",
               frame_err, frame_ok, err_code, err_count, led);
    end
  endtask

  task automatic test_blink;
    logic [3:0] exp_led;
    send_frame(8'hA5, 8'h01, 8'h00, 8'hA6);
    checks++;
    if (led !== 4'h0) begin failures++; $display("FAIL blink_clear: got %0h required 0", led); end
    send_frame(8'hA5, 8'h03, 8'h03, 8'hAB);
    for (int k = 0; k < 12; k++) begin
      exp_led = (((k / 4) % 2) == 1) ? 4'h3 : 4'h0;
      checks++;
      if (led !== exp_led) begin
        failures++; $display("FAIL blink_led[%0d]: got %0h required %0h", k, led, exp_led);
      end
      @(negedge clk);
    end
    send_frame(8'hA5, 8'h01, 8'h08, 8'hAE);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (led !== 4'h8) begin failures++; $display("FAIL blink_stop[%0d]: got %0h required 8", k, led); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    int seen_at = -1;
    int pulses  = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        pulses++;
        if (seen_at < 0) seen_at = c;
      end
    end
    checks++;
    if (seen_at != 16 || pulses != 1) begin
      failures++; $display("FAIL timeout_timing: got at=%0d pulses=%0d required at=16 pulses=1", seen_at, pulses);
    end
    checks++;
    if (err_code !== 2'b01 || busy !== 1'b0 || err_count !== 8'd2) begin
      failures++;
      $display("FAIL timeout_status: got code=%0d busy=%0b cnt=%0d required 1 0 2", err_code, busy, err_count);
    end
    send_frame(8'hA5, 8'h02, 8'h0F, 8'hB6);
    checks++;
    if (frame_ok !== 1'b1 || led !== 4'h7) begin
      failures++; $display("FAIL timeout_recover: got ok=%0b led=%0h required 1 7", frame_ok, led);
    end
  endtask

  task automatic test_idle_garbage_and_badcmd;
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h12;
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i]);
      checks++;
      if (frame_ok !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_junk[%0d]: got ok=%0b err=%0b busy=%0b required 0 0 0", i, frame_ok, frame_err, busy);
      end
    end
    send_frame(8'hA5, 8'h07, 8'h00, 8'hAC);
    checks++;
    if (frame_err !== 1'b1 || frame_ok !== 1'b0 || err_code !== 2'b11 || err_count !== 8'd3 || led !== 4'h7) begin
      failures++;
      $display("FAIL bad_cmd: got err=%0b ok=%0b code=%0d cnt=%0d led=%0h required 1 0 3 3 7",
               frame_err, frame_ok, err_code, err_count, led);
    end
  endtask

  task automatic test_reset_midframe;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h05);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({led, busy, frame_ok, frame_err, err_code, err_count} !== 17'h0) begin
      failures++;
      $display("FAIL midframe_reset: got led=%0h busy=%0b ok=%0b err=%0b code=%0d cnt=%0d required all 0",
               led, busy, frame_ok, frame_err, err_code, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'hAB);
    checks++;
    if (frame_ok !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 || led !== 4'h0) begin
      failures++;
      $display("FAIL stray_chk: got ok=%0b err=%0b busy=%0b led=%0h required 0 0 0 0", frame_ok, frame_err, busy, led);
    end
  endtask

  // byte arrives on exactly the cycle the timeout would expire
  task automatic test_timeout_race;
    send_byte(8'hA5);
    repeat (14) @(negedge clk);
    send_byte(8'h01);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_race: got err=%0b busy=%0b required 0 1", frame_err, busy);
    end
    send_byte(8'h06);
    send_byte(8'hAC);
    checks++;
    if (frame_ok !== 1'b1 || led !== 4'h6 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL timeout_race_exec: got ok=%0b led=%0h cnt=%0d required 1 6 0", frame_ok, led, err_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [8];
    int ok_pulses = 0;
    bytes[0] = 8'hA5; bytes[1] = 8'h01; bytes[2] = 8'h03; bytes[3] = 8'hA9;
    bytes[4] = 8'hA5; bytes[5] = 8'h02; bytes[6] = 8'h01; bytes[7] = 8'hA8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame_ok === 1'b1) ok_pulses++;
      if (i == 4) begin
        checks++;
        if (frame_ok !== 1'b1 || led !== 4'h3) begin
          failures++; $display("FAIL b2b_first: got ok=%0b led=%0h required 1 3", frame_ok, led);
        end
      end
      rx_data = bytes[i];
      rx_done = 1'b1;
    end
    @(negedge clk);
    rx_done = 1'b0;
    if (frame_ok === 1'b1) ok_pulses++;
    checks++;
    if (frame_ok !== 1'b1 || led !== 4'h2 || ok_pulses != 2) begin
      failures++;
      $display("FAIL b2b_second: got ok=%0b led=%0h pulses=%0d required 1 2 2", frame_ok, led, ok_pulses);
    end
  endtask

  task automatic test_err_saturation;
    for (int i = 0; i < 256; i++) send_frame(8'hA5, 8'h01, 8'h00, 8'h00);
    checks++;
    if (err_count !== 8'd255 || frame_err !== 1'b1 || err_code !== 2'b10) begin
      failures++;
      $display("FAIL saturation: got cnt=%0d err=%0b code=%0d required 255 1 2", err_count, frame_err, err_code);
    end
    send_frame(8'hA5, 8'h05, 8'h00, 8'hAA);
    checks++;
    if (err_count !== 8'd255 || frame_err !== 1'b1 || err_code !== 2'b11 || led !== 4'h2) begin
      failures++;
      $display("FAIL saturation_hold: got cnt=%0d err=%0b code=%0d led=%0h required 255 1 3 2",
               err_count, frame_err, err_code, led);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle_and_chksum();
    test_blink();
    test_timeout();
    test_idle_garbage_and_badcmd();
    test_reset_midframe();
    test_timeout_race();
    test_back_to_back();
    test_err_saturation();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
